// File: rtl/tcdm_tag_shadow_bridge.sv
// Bridge from a tagged (DIFT) TCDM slave port to an untagged TCDM master port.
// Byte tags are kept in a shadow store on write grants and re-attached to read
// data when the in-order response returns.
//
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   s_req_i .. s_wdata_i             tagged request in
//   s_gnt_o                          tagged grant (combinational)
//   s_r_valid_o, s_r_opc_o           response valid / error, passed through
//   s_r_rdata_o                      tagged read data (combinational)
//   m_req_o .. m_wdata_o             untagged request out (combinational)
//   m_gnt_i, m_r_valid_i, m_r_opc_i, m_r_rdata_i   untagged handshake / response in
//   err_o                            sticky: response seen with nothing outstanding
module tcdm_tag_shadow_bridge #(
   parameter int unsigned         NB          = 4,
   parameter int unsigned         TAG_W       = 1,
   parameter logic [31:0]         TAG_BASE    = 32'h1C00_0000,
   parameter int unsigned         TAG_DEPTH   = 256,
   parameter int unsigned         MAX_OUT     = 4,
   parameter logic [TAG_W-1:0]    DEFAULT_TAG = '1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    s_req_i,
   input  logic [31:0]             s_add_i,
   input  logic                    s_wen_i,
   input  logic [NB-1:0]           s_be_i,
   input  logic [NB*(8+TAG_W)-1:0] s_wdata_i,
   output logic                    s_gnt_o,
   output logic                    s_r_valid_o,
   output logic                    s_r_opc_o,
   output logic [NB*(8+TAG_W)-1:0] s_r_rdata_o,
   output logic                    m_req_o,
   output logic [31:0]             m_add_o,
   output logic                    m_wen_o,
   output logic [NB-1:0]           m_be_o,
   output logic [8*NB-1:0]         m_wdata_o,
   input  logic                    m_gnt_i,
   input  logic                    m_r_valid_i,
   input  logic                    m_r_opc_i,
   input  logic [8*NB-1:0]         m_r_rdata_i,
   output logic                    err_o
);

   localparam int unsigned LW    = 8 + TAG_W;
   localparam int unsigned GW    = NB * TAG_W;
   localparam int unsigned IDX_W = $clog2(TAG_DEPTH);
   localparam int unsigned SH    = $clog2(NB);
   localparam int unsigned PTR_W = $clog2(MAX_OUT);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [31:0] SPAN  = 32'(NB * TAG_DEPTH);

   logic              full;
   logic              fifo_empty;
   logic              hs;
   logic              pop;
   logic              covered;
   logic              store_we;
   logic [31:0]       off;
   logic [IDX_W-1:0]  idx;
   logic [GW-1:0]     wr_tags;
   logic [GW-1:0]     lk_tags;
   logic [GW-1:0]     merged_tags;
   logic [GW-1:0]     rsp_tags;

   logic [GW-1:0]     tag_mem  [TAG_DEPTH];
   logic [NB-1:0]     vld_mem  [TAG_DEPTH];
   logic [GW-1:0]     fifo_mem [MAX_OUT];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              err_q;

   // Request path: combinational pass-through, blocked while the FIFO is full.
   // full comes from the registered count, so a same-cycle pop does not unblock.
   assign full       = (count == CNT_W'(MAX_OUT));
   assign fifo_empty = (count == '0);
   assign m_req_o    = s_req_i & ~full;
   assign s_gnt_o    = m_gnt_i & ~full;
   assign m_add_o    = s_add_i;
   assign m_wen_o    = s_wen_i;
   assign m_be_o     = s_be_i;
   assign hs         = s_req_i & s_gnt_o;
   assign pop        = m_r_valid_i & ~fifo_empty;

   // Coverage test via offset so TAG_BASE + SPAN cannot overflow.
   assign off      = s_add_i - TAG_BASE;
   assign covered  = (s_add_i >= TAG_BASE) && (off < SPAN);
   assign idx      = off[SH +: IDX_W];
   assign store_we = hs & ~s_wen_i & covered;

   assign s_r_valid_o = m_r_valid_i;
   assign s_r_opc_o   = m_r_opc_i;
   assign err_o       = err_q;

   // Per-byte lane split/merge between tagged and untagged layouts.
   always_comb begin : lanes
      m_wdata_o   = '0;
      wr_tags     = '0;
      lk_tags     = '0;
      merged_tags = '0;
      s_r_rdata_o = '0;
      rsp_tags    = fifo_empty ? {NB{DEFAULT_TAG}} : fifo_mem[rd_ptr];
      for (int k = 0; k < NB; k++) begin
         m_wdata_o[8*k +: 8]       = s_wdata_i[LW*k +: 8];
         wr_tags[TAG_W*k +: TAG_W] = s_wdata_i[LW*k+8 +: TAG_W];
         lk_tags[TAG_W*k +: TAG_W] = (covered && vld_mem[idx][k]) ?
                                     tag_mem[idx][TAG_W*k +: TAG_W] : DEFAULT_TAG;
         merged_tags[TAG_W*k +: TAG_W] = s_be_i[k] ? wr_tags[TAG_W*k +: TAG_W]
                                                   : tag_mem[idx][TAG_W*k +: TAG_W];
         s_r_rdata_o[LW*k +: 8]       = m_r_rdata_i[8*k +: 8];
         s_r_rdata_o[LW*k+8 +: TAG_W] = rsp_tags[TAG_W*k +: TAG_W];
      end
   end

   // Per-byte valid bits; cleared on reset so old tags read as DEFAULT_TAG.
   always_ff @(posedge clk_i) begin : store_vld
      if (rst_i) begin
         for (int i = 0; i < TAG_DEPTH; i++) vld_mem[i] <= '0;
      end else if (store_we) begin
         vld_mem[idx] <= vld_mem[idx] | s_be_i;
      end
   end

   // Tag payload; no reset needed, gated by the valid bits.
   always_ff @(posedge clk_i) begin : store_tag
      if (!rst_i && store_we) tag_mem[idx] <= merged_tags;
   end

   // In-order response FIFO carrying the tags looked up at each handshake.
   always_ff @(posedge clk_i) begin : resp_fifo
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (hs) begin
            fifo_mem[wr_ptr] <= lk_tags;
            wr_ptr           <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({hs, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Sticky protocol error.
   always_ff @(posedge clk_i) begin : err_flag
      if (rst_i)                           err_q <= 1'b0;
      else if (m_r_valid_i && fifo_empty)  err_q <= 1'b1;
   end

endmodule

// File: tb/tb_tcdm_tag_shadow_bridge.sv
// Scoreboard bench for tcdm_tag_shadow_bridge (NB=4, TAG_W=1, DEFAULT_TAG=1).
module tb_tcdm_tag_shadow_bridge;

   localparam logic [31:0] TAG_BASE = 32'h1C00_0000;
   localparam int unsigned SPAN     = 1024;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        s_req_i;
   logic [31:0] s_add_i;
   logic        s_wen_i;
   logic [3:0]  s_be_i;
   logic [35:0] s_wdata_i;
   logic        s_gnt_o;
   logic        s_r_valid_o;
   logic        s_r_opc_o;
   logic [35:0] s_r_rdata_o;
   logic        m_req_o;
   logic [31:0] m_add_o;
   logic        m_wen_o;
   logic [3:0]  m_be_o;
   logic [31:0] m_wdata_o;
   logic        m_gnt_i;
   logic        m_r_valid_i;
   logic        m_r_opc_i;
   logic [31:0] m_r_rdata_i;
   logic        err_o;

   tcdm_tag_shadow_bridge dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .s_req_i(s_req_i), .s_add_i(s_add_i), .s_wen_i(s_wen_i), .s_be_i(s_be_i),
      .s_wdata_i(s_wdata_i), .s_gnt_o(s_gnt_o), .s_r_valid_o(s_r_valid_o),
      .s_r_opc_o(s_r_opc_o), .s_r_rdata_o(s_r_rdata_o),
      .m_req_o(m_req_o), .m_add_o(m_add_o), .m_wen_o(m_wen_o), .m_be_o(m_be_o),
      .m_wdata_o(m_wdata_o), .m_gnt_i(m_gnt_i), .m_r_valid_i(m_r_valid_i),
      .m_r_opc_i(m_r_opc_i), .m_r_rdata_i(m_r_rdata_i), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic       chk;
      logic [3:0] tags;
   } exp_t;

   exp_t        exp_q[$];
   logic [3:0]  mtag[256];
   logic [3:0]  mvld[256];
   logic [35:0] last_rdata;
   int          n_chk  = 0;
   int          n_fail = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [35:0] tagify(input logic [31:0] d, input logic [3:0] t);
      logic [35:0] r;
      for (int k = 0; k < 4; k++) begin
         r[9*k +: 8] = d[8*k +: 8];
         r[9*k+8]    = t[k];
      end
      return r;
   endfunction

   function automatic logic [3:0] lookup(input logic [31:0] a);
      logic [31:0] off;
      logic [3:0]  t;
      int          i;
      off = a - TAG_BASE;
      t   = 4'hF;
      if (a >= TAG_BASE && off < SPAN) begin
         i = int'(off >> 2);
         for (int k = 0; k < 4; k++) t[k] = mvld[i][k] ? mtag[i][k] : 1'b1;
      end
      return t;
   endfunction

   // Updates the model and scoreboard at the handshake cycle.
   task automatic model_hs(input logic [31:0] a, input logic wen, input logic [3:0] be,
                           input logic [3:0] t);
      logic [31:0] off;
      int          i;
      exp_t        e;
      off = a - TAG_BASE;
      if (wen) begin
         e.chk = 1'b1; e.tags = lookup(a);
      end else begin
         e.chk = 1'b0; e.tags = 4'h0;
         if (a >= TAG_BASE && off < SPAN) begin
            i = int'(off >> 2);
            for (int k = 0; k < 4; k++)
               if (be[k]) begin mtag[i][k] = t[k]; mvld[i][k] = 1'b1; end
         end
      end
      exp_q.push_back(e);
   endtask

   // Entered and left at posedge+1.
   task automatic do_req(input logic [31:0] a, input logic wen, input logic [3:0] be,
                         input logic [31:0] d, input logic [3:0] t);
      int n = 0;
      s_req_i = 1'b1; s_add_i = a; s_wen_i = wen; s_be_i = be; s_wdata_i = tagify(d, t);
      @(negedge clk_i);
      while (!s_gnt_o && n < 20) begin n++; @(negedge clk_i); end
      if (!s_gnt_o) begin
         check("gnt_timeout", 64'(s_gnt_o), 64'd1);
      end else begin
         check("m_add", 64'(m_add_o), 64'(a));
         if (!wen) check("m_wdata", 64'(m_wdata_o), 64'(d));
         model_hs(a, wen, be, t);
      end
      @(posedge clk_i); #1;
      s_req_i = 1'b0;
   endtask

   // Called at negedge while m_r_valid_i is high.
   task automatic rsp_check(input logic [31:0] rd);
      exp_t e;
      check("r_valid", 64'(s_r_valid_o), 64'd1);
      last_rdata = s_r_rdata_o;
      if (exp_q.size() == 0) begin
         check("r_empty", 64'(s_r_rdata_o), 64'(tagify(rd, 4'hF)));
      end else begin
         e = exp_q.pop_front();
         if (e.chk) check("r_rdata", 64'(s_r_rdata_o), 64'(tagify(rd, e.tags)));
      end
   endtask

   task automatic do_rsp(input logic [31:0] rd);
      m_r_valid_i = 1'b1; m_r_rdata_i = rd;
      @(negedge clk_i);
      rsp_check(rd);
      @(posedge clk_i); #1;
      m_r_valid_i = 1'b0;
   endtask

   task automatic pulse_reset();
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      rst_i = 1'b0;
      for (int i = 0; i < 256; i++) mvld[i] = 4'h0;
      exp_q.delete();
      @(negedge clk_i);
      check("rst_err", 64'(err_o), 64'd0);
      check("rst_gnt", 64'(s_gnt_o), 64'd1);
      @(posedge clk_i); #1;
   endtask

   initial begin
      logic [31:0] a, d;
      int          n;
      for (int i = 0; i < 256; i++) begin mvld[i] = 4'h0; mtag[i] = 4'h0; end
      rst_i = 1'b1; s_req_i = 1'b0; s_add_i = '0; s_wen_i = 1'b1; s_be_i = '0;
      s_wdata_i = '0; m_gnt_i = 1'b1; m_r_valid_i = 1'b0; m_r_opc_i = 1'b0;
      m_r_rdata_i = '0;
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      check("reset_err", 64'(err_o), 64'd0);
      check("reset_gnt", 64'(s_gnt_o), 64'd1);
      check("reset_rvalid", 64'(s_r_valid_o), 64'd0);
      @(posedge clk_i); #1;

      // Default tags on a never-written covered word.
      do_req(TAG_BASE + 8, 1'b1, 4'hF, 32'h0, 4'h0);
      do_rsp(32'hA1B2C3D4);
      check("plan_default", 64'(last_rdata),
            64'({1'b1, 8'hA1, 1'b1, 8'hB2, 1'b1, 8'hC3, 1'b1, 8'hD4}));

      // Partial write with zero tags, read back.
      do_req(TAG_BASE + 4, 1'b0, 4'b0101, 32'hDEADBEEF, 4'h0);
      do_rsp(32'h0);
      do_req(TAG_BASE + 4, 1'b1, 4'hF, 32'h0, 4'h0);
      do_rsp(32'h11223344);
      check("plan_partial", 64'(last_rdata),
            64'({1'b1, 8'h11, 1'b0, 8'h22, 1'b1, 8'h33, 1'b0, 8'h44}));

      // Write immediately followed by a read of the same word.
      do_req(TAG_BASE + 12, 1'b0, 4'b1010, 32'h55AA55AA, 4'b0000);
      do_req(TAG_BASE + 12, 1'b1, 4'hF, 32'h0, 4'h0);
      do_rsp(32'h0);
      do_rsp(32'h01020304);
      check("wr_then_rd", 64'(last_rdata),
            64'({1'b0, 8'h01, 1'b1, 8'h02, 1'b0, 8'h03, 1'b1, 8'h04}));

      // Fill the FIFO, then verify the block and its one-cycle release.
      for (int i = 0; i < 4; i++) do_req(TAG_BASE + 32'(4*i), 1'b1, 4'hF, 32'h0, 4'h0);
      s_req_i = 1'b1; s_add_i = TAG_BASE + 4; s_wen_i = 1'b1; s_be_i = 4'hF;
      @(negedge clk_i);
      check("full_gnt", 64'(s_gnt_o), 64'd0);
      check("full_mreq", 64'(m_req_o), 64'd0);
      @(posedge clk_i); #1;
      m_r_valid_i = 1'b1; m_r_rdata_i = 32'hCAFEF00D;
      @(negedge clk_i);
      check("full_pop_gnt", 64'(s_gnt_o), 64'd0);
      rsp_check(32'hCAFEF00D);
      @(posedge clk_i); #1;
      m_r_valid_i = 1'b0;
      @(negedge clk_i);
      check("unblock_gnt", 64'(s_gnt_o), 64'd1);
      if (s_gnt_o) model_hs(TAG_BASE + 4, 1'b1, 4'hF, 4'h0);
      @(posedge clk_i); #1;
      s_req_i = 1'b0;
      for (int i = 0; i < 4; i++) do_rsp(32'h1000_0000 + 32'(i));

      // Uncovered words: above and below the covered window.
      do_req(TAG_BASE + SPAN, 1'b0, 4'hF, 32'h0, 4'h0);
      do_req(TAG_BASE - 4, 1'b0, 4'hF, 32'h0, 4'h0);
      do_rsp(32'h0);
      do_rsp(32'h0);
      do_req(TAG_BASE + SPAN, 1'b1, 4'hF, 32'h0, 4'h0);
      do_req(TAG_BASE + 16, 1'b1, 4'hF, 32'h0, 4'h0);
      do_req(TAG_BASE + SPAN - 4, 1'b1, 4'hF, 32'h0, 4'h0);
      do_rsp(32'h77777777);
      check("uncov_rd", 64'(last_rdata), 64'(tagify(32'h77777777, 4'hF)));
      do_rsp(32'h0);
      do_rsp(32'h0);

      // Response with nothing outstanding.
      do_rsp(32'h89ABCDEF);
      check("orphan_rdata", 64'(last_rdata), 64'(tagify(32'h89ABCDEF, 4'hF)));
      @(negedge clk_i);
      check("err_set", 64'(err_o), 64'd1);
      repeat (3) @(posedge clk_i);
      #1;
      @(negedge clk_i);
      check("err_hold", 64'(err_o), 64'd1);
      @(posedge clk_i); #1;
      pulse_reset();

      // Reset mid-operation: outstanding entry dropped, tags forgotten.
      do_req(TAG_BASE, 1'b0, 4'hF, 32'h0, 4'h0);
      do_rsp(32'h0);
      do_req(TAG_BASE, 1'b1, 4'hF, 32'h0, 4'h0);
      pulse_reset();
      do_rsp(32'h2468ACE0);
      @(negedge clk_i);
      check("discard_err", 64'(err_o), 64'd1);
      @(posedge clk_i); #1;
      pulse_reset();
      do_req(TAG_BASE, 1'b1, 4'hF, 32'h0, 4'h0);
      do_rsp(32'h13579BDF);
      check("rst_tags", 64'(last_rdata), 64'(tagify(32'h13579BDF, 4'hF)));
      @(negedge clk_i);
      check("rst_no_err", 64'(err_o), 64'd0);
      @(posedge clk_i); #1;

      // Random bursts across the window edges.
      for (int it = 0; it < 30; it++) begin
         n = int'($urandom_range(1, 4));
         for (int j = 0; j < n; j++) begin
            case ($urandom_range(0, 5))
               0:       a = TAG_BASE - 4;
               1:       a = TAG_BASE + SPAN;
               2:       a = TAG_BASE + SPAN - 4;
               default: a = TAG_BASE + 32'(4 * $urandom_range(0, 7));
            endcase
            d = $urandom;
            do_req(a, 1'($urandom_range(0, 1)), 4'($urandom), d, 4'($urandom));
         end
         for (int j = 0; j < n; j++) do_rsp($urandom);
      end
      @(negedge clk_i);
      check("final_err", 64'(err_o), 64'd0);
      check("final_q", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
